fpu_div_normalizer: RTL

//  Post-divider stage. Takes the raw fixed-point quotient/remainder from the sequential mantissa

---
 rtl/fpu_div_normalizer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_div_normalizer.sv
// Post-divider normalize / RNE round / pack stage for the FPU divide path (FP16 by default).
// Define FPU_DIVNORM_FLAGS_EN to add the overflow/underflow/inexact flag outputs.
module fpu_div_normalizer #(
    parameter int WIDTH = 16,
    parameter int EXPW  = 5,
    parameter int FRACW = 10,
    parameter int QFRAC = 13,
    parameter int BIAS  = 15
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_quot,
    input  logic [WIDTH-1:0]        in_rem,
    input  logic [EXPW+1:0]         in_exp,
    input  logic                    in_sign,
    input  logic [1:0]              in_special,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXPW+FRACW:0]     out_result
`ifdef FPU_DIVNORM_FLAGS_EN
    ,
    output logic                    out_overflow,
    output logic                    out_underflow,
    output logic                    out_inexact
`endif
);

    localparam int IEXPW   = EXPW + 3;
    localparam int RESW    = 1 + EXPW + FRACW;
    localparam int CNTW    = $clog2(WIDTH);
    // Biased exponent of infinity: one past the largest finite exponent (2*BIAS).
    localparam int EXP_INF = 2 * BIAS + 1;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [IEXPW-1:0]  exp_q, exp_d;
    logic              sticky_q, sticky_d;
    logic              sign_q, sign_d;
    logic [1:0]        special_q, special_d;
    logic [CNTW-1:0]   shcnt_q, shcnt_d;
    logic [RESW-1:0]   result_q, result_d;

    logic [FRACW-1:0]  mant;
    logic [FRACW:0]    mant_sum;
    logic              guard, sticky_r, inc;
    logic [IEXPW-1:0]  exp_rnd;
    logic              exp_ovf, exp_unf;
    logic [RESW-1:0]   pack;

    // Rounding view of the normalized quotient: leading one sits at bit QFRAC.
    always_comb begin
        mant     = q_q[QFRAC-1 -: FRACW];
        guard    = q_q[QFRAC-FRACW-1];
        sticky_r = sticky_q | (|q_q[QFRAC-FRACW-2:0]);
        inc      = guard & (sticky_r | mant[0]);
        mant_sum = {1'b0, mant} + {{FRACW{1'b0}}, inc};
        exp_rnd  = exp_q + {{(IEXPW-1){1'b0}}, mant_sum[FRACW]};
        exp_ovf  = !exp_rnd[IEXPW-1] && (exp_rnd >= IEXPW'(EXP_INF));
        exp_unf  = exp_rnd[IEXPW-1] || (exp_rnd == '0);
    end

    always_comb begin
        pack = {sign_q, {EXPW{1'b0}}, {FRACW{1'b0}}};
        case (special_q)
            2'b01: pack = {sign_q, {EXPW{1'b0}}, {FRACW{1'b0}}};
            2'b10: pack = {sign_q, {EXPW{1'b1}}, {FRACW{1'b0}}};
            2'b11: pack = {1'b0, {EXPW{1'b1}}, 1'b1, {(FRACW-1){1'b0}}};
            default: begin
                if (q_q == '0 || exp_unf)
                    pack = {sign_q, {EXPW{1'b0}}, {FRACW{1'b0}}};
                else if (exp_ovf)
                    pack = {sign_q, {EXPW{1'b1}}, {FRACW{1'b0}}};
                else
                    pack = {sign_q, exp_rnd[EXPW-1:0], mant_sum[FRACW-1:0]};
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        exp_d     = exp_q;
        sticky_d  = sticky_q;
        sign_d    = sign_q;
        special_d = special_q;
        shcnt_d   = shcnt_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    q_d       = in_quot;
                    exp_d     = {in_exp[EXPW+1], in_exp};
                    sticky_d  = |in_rem;
                    sign_d    = in_sign;
                    special_d = in_special;
                    shcnt_d   = '0;
                    state_d   = NORM;
                end
            end
            NORM: begin
                if (special_q != 2'b00 || q_q == '0) begin
                    state_d = ROUND;
                end else if (q_q[QFRAC+1]) begin
                    q_d      = q_q >> 1;
                    sticky_d = sticky_q | q_q[0];
                    exp_d    = exp_q + IEXPW'(1);
                    state_d  = ROUND;
                end else if (q_q[QFRAC] || shcnt_q == CNTW'(WIDTH-1)) begin
                    state_d = ROUND;
                end else begin
                    q_d     = q_q << 1;
                    exp_d   = exp_q - IEXPW'(1);
                    shcnt_d = shcnt_q + CNTW'(1);
                end
            end
            ROUND: begin
                result_d = pack;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            q_q       <= '0;
            exp_q     <= '0;
            sticky_q  <= 1'b0;
            sign_q    <= 1'b0;
            special_q <= 2'b00;
            shcnt_q   <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            exp_q     <= exp_d;
            sticky_q  <= sticky_d;
            sign_q    <= sign_d;
            special_q <= special_d;
            shcnt_q   <= shcnt_d;
            result_q  <= result_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;

`ifdef FPU_DIVNORM_FLAGS_EN
    logic [2:0] flags_q, flags_d;
    logic       normal_path, ovf_f, unf_f;

    // Flags only come from finite nonzero quotients; specials and exact zero are exact.
    always_comb begin
        normal_path = (special_q == 2'b00) && (q_q != '0);
        ovf_f       = normal_path && exp_ovf;
        unf_f       = normal_path && !exp_ovf && exp_unf;
        flags_d     = flags_q;
        if (state_q == ROUND)
            flags_d = {ovf_f, unf_f, ovf_f | unf_f | (normal_path & (guard | sticky_r))};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            flags_q <= '0;
        else
            flags_q <= flags_d;
    end

    assign out_overflow  = flags_q[2];
    assign out_underflow = flags_q[1];
    assign out_inexact   = flags_q[0];
`endif

endmodule
